// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, zero-register constant and writeback request type
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // wb_reg stands for the destination register ("reg" is a keyword)
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wb_reg;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-requester grant, round-robin or fixed with requester 1 winning
module wb_rr_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    logic favour1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            if ((RR_EN != 0) && !favour1) grant0 = 1'b1;
            else                          grant1 = 1'b1;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

    // A grant implies valid, so every grant is an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      favour1 <= 1'b0;
        else if (grant0) favour1 <= 1'b1;
        else if (grant1) favour1 <= 1'b0;
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - write-port arbiter, busy scoreboard, registered writeback (option: WB_BYPASS_EN)
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int DATA_W        = regfile_pkg::DATA_W,
    parameter int ADDR_W        = regfile_pkg::ADDR_W,
    parameter int RR_EN_DEFAULT = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ0_VALID,
    input  logic [ADDR_W-1:0]     REQ0_REG,
    input  logic [DATA_W-1:0]     REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [ADDR_W-1:0]     REQ1_REG,
    input  logic [DATA_W-1:0]     REQ1_DATA,
    output logic                  REQ1_READY,
    input  logic                  ISSUE_VALID,
    input  logic [ADDR_W-1:0]     ISSUE_RS1,
    input  logic [ADDR_W-1:0]     ISSUE_RS2,
    input  logic [ADDR_W-1:0]     ISSUE_RD,
    output logic                  ISSUE_STALL,
    input  logic                  FLUSH,
`ifdef WB_BYPASS_EN
    output logic                  BYP_HIT1,
    output logic                  BYP_HIT2,
    output logic [DATA_W-1:0]     BYP_DATA1,
    output logic [DATA_W-1:0]     BYP_DATA2,
`endif
    output logic                  WE,
    output logic [ADDR_W-1:0]     WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [2**ADDR_W-1:0]  BUSY_VEC
);
    localparam int NREG = 2 ** ADDR_W;

    logic              grant0, grant1, accept;
    wb_req_t           win;
    logic [NREG-1:0]   busy, busy_nxt;
    logic              src1_busy, src2_busy, rd_busy, do_set;

    wb_rr_arbiter #(.RR_EN(RR_EN_DEFAULT)) u_arb (
        .clk    (CLK),
        .rst_n  (RST_N),
        .valid0 (REQ0_VALID),
        .valid1 (REQ1_VALID),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign REQ0_READY = grant0;
    assign REQ1_READY = grant1;
    assign accept     = grant0 | grant1;

    always_comb begin
        win = '0;
        if (grant1)      win = '{valid: 1'b1, wb_reg: REQ1_REG, data: REQ1_DATA};
        else if (grant0) win = '{valid: 1'b1, wb_reg: REQ0_REG, data: REQ0_DATA};
    end

    assign src1_busy = (ISSUE_RS1 != ZERO_REG) && busy[ISSUE_RS1];
    assign src2_busy = (ISSUE_RS2 != ZERO_REG) && busy[ISSUE_RS2];
    assign rd_busy   = (ISSUE_RD  != ZERO_REG) && busy[ISSUE_RD];

`ifdef WB_BYPASS_EN
    assign BYP_HIT1  = accept && (ISSUE_RS1 != ZERO_REG) && (win.wb_reg == ISSUE_RS1);
    assign BYP_HIT2  = accept && (ISSUE_RS2 != ZERO_REG) && (win.wb_reg == ISSUE_RS2);
    assign BYP_DATA1 = win.data;
    assign BYP_DATA2 = win.data;
    // A source arriving on this cycle's writeback is taken from the bypass instead
    assign ISSUE_STALL = (src1_busy && !BYP_HIT1) || (src2_busy && !BYP_HIT2) || rd_busy;
`else
    assign ISSUE_STALL = src1_busy || src2_busy || rd_busy;
`endif

    assign do_set = ISSUE_VALID && !ISSUE_STALL && (ISSUE_RD != ZERO_REG);

    // Clear before set so a new in-flight write to the same index survives
    always_comb begin
        busy_nxt = busy;
        if (accept) busy_nxt[win.wb_reg] = 1'b0;
        if (do_set) busy_nxt[ISSUE_RD]   = 1'b1;
        busy_nxt[0] = 1'b0;
        if (FLUSH)  busy_nxt = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy      <= '0;
            WE        <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            busy <= busy_nxt;
            if (accept) begin
                WE        <= (win.wb_reg != ZERO_REG);
                WriteReg  <= win.wb_reg;
                WriteData <= win.data;
            end else begin
                WE        <= 1'b0;
            end
        end
    end

    assign BUSY_VEC = busy;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed self-checking bench, round-robin and fixed-priority instances
module tb_regfile_wb_scheduler;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ0_VALID, REQ1_VALID, ISSUE_VALID, FLUSH;
    logic [4:0]  REQ0_REG, REQ1_REG, ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
    logic [31:0] REQ0_DATA, REQ1_DATA;

    logic        r0_rdy, r1_rdy, stall, we;
    logic [4:0]  wreg;
    logic [31:0] wdata, busy;
    logic        f_r0_rdy, f_r1_rdy, f_stall, f_we;
    logic [4:0]  f_wreg;
    logic [31:0] f_wdata, f_busy;
`ifdef WB_BYPASS_EN
    logic        hit1, hit2, f_hit1, f_hit2;
    logic [31:0] bdata1, bdata2, f_bdata1, f_bdata2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    regfile_wb_scheduler #(.RR_EN_DEFAULT(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_REG(REQ0_REG), .REQ0_DATA(REQ0_DATA), .REQ0_READY(r0_rdy),
        .REQ1_VALID(REQ1_VALID), .REQ1_REG(REQ1_REG), .REQ1_DATA(REQ1_DATA), .REQ1_READY(r1_rdy),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2), .ISSUE_RD(ISSUE_RD),
        .ISSUE_STALL(stall), .FLUSH(FLUSH),
`ifdef WB_BYPASS_EN
        .BYP_HIT1(hit1), .BYP_HIT2(hit2), .BYP_DATA1(bdata1), .BYP_DATA2(bdata2),
`endif
        .WE(we), .WriteReg(wreg), .WriteData(wdata), .BUSY_VEC(busy)
    );

    regfile_wb_scheduler #(.RR_EN_DEFAULT(0)) dut_fix (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_REG(REQ0_REG), .REQ0_DATA(REQ0_DATA), .REQ0_READY(f_r0_rdy),
        .REQ1_VALID(REQ1_VALID), .REQ1_REG(REQ1_REG), .REQ1_DATA(REQ1_DATA), .REQ1_READY(f_r1_rdy),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2), .ISSUE_RD(ISSUE_RD),
        .ISSUE_STALL(f_stall), .FLUSH(FLUSH),
`ifdef WB_BYPASS_EN
        .BYP_HIT1(f_hit1), .BYP_HIT2(f_hit2), .BYP_DATA1(f_bdata1), .BYP_DATA2(f_bdata2),
`endif
        .WE(f_we), .WriteReg(f_wreg), .WriteData(f_wdata), .BUSY_VEC(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; FLUSH = 1'b0; ISSUE_VALID = 1'b0;
        REQ0_VALID = 1'b0; REQ0_REG = '0; REQ0_DATA = '0;
        REQ1_VALID = 1'b0; REQ1_REG = '0; REQ1_DATA = '0;
        ISSUE_RS1 = '0; ISSUE_RS2 = '0; ISSUE_RD = '0;
        tick(); tick();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wreg", {27'd0, wreg}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        RST_N = 1'b1;
        tick();

        // single ALU writeback, one-cycle latency
        REQ0_VALID = 1'b1; REQ0_REG = 5'd5; REQ0_DATA = 32'h1234;
        #1;
        chk("t1_r0_ready", {31'd0, r0_rdy}, 32'd1);
        chk("t1_r1_ready", {31'd0, r1_rdy}, 32'd0);
        chk("t1_fix_r0_ready", {31'd0, f_r0_rdy}, 32'd1);
        tick();
        REQ0_VALID = 1'b0;
        chk("t1_we", {31'd0, we}, 32'd1);
        chk("t1_wreg", {27'd0, wreg}, 32'd5);
        chk("t1_wdata", wdata, 32'h1234);
        tick();
        chk("t1_we_drop", {31'd0, we}, 32'd0);
        chk("t1_wreg_hold", {27'd0, wreg}, 32'd5);

        // RAW hazard on reg 7 held until the load writes it
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
        #1;
        chk("t3_issue_nostall", {31'd0, stall}, 32'd0);
        tick();
        ISSUE_VALID = 1'b0; ISSUE_RD = 5'd0; ISSUE_RS1 = 5'd7;
        #1;
        chk("t3_busy7", busy, 32'h0000_0080);
        chk("t3_stall_a", {31'd0, stall}, 32'd1);
        tick();
        chk("t3_stall_b", {31'd0, stall}, 32'd1);
        REQ1_VALID = 1'b1; REQ1_REG = 5'd7; REQ1_DATA = 32'hCAFE;
        #1;
        chk("t3_r1_ready", {31'd0, r1_rdy}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("t3_stall_accept", {31'd0, stall}, 32'd0);
        chk("t3_byp_hit1", {31'd0, hit1}, 32'd1);
        chk("t3_byp_data1", bdata1, 32'hCAFE);
        chk("t3_byp_hit2", {31'd0, hit2}, 32'd0);
`else
        chk("t3_stall_accept", {31'd0, stall}, 32'd1);
`endif
        tick();
        REQ1_VALID = 1'b0;
        #1;
        chk("t3_stall_clear", {31'd0, stall}, 32'd0);
        chk("t3_busy_clear", busy, 32'd0);
        chk("t3_we", {31'd0, we}, 32'd1);
        chk("t3_wreg", {27'd0, wreg}, 32'd7);
        chk("t3_wdata", wdata, 32'hCAFE);
        ISSUE_RS1 = 5'd0;

        // contention: last grant was REQ1, so round-robin starts with REQ0
        REQ0_VALID = 1'b1; REQ0_REG = 5'd3; REQ0_DATA = 32'h33;
        REQ1_VALID = 1'b1; REQ1_REG = 5'd4; REQ1_DATA = 32'h44;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_r0_%0d", i), {31'd0, r0_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_r1_%0d", i), {31'd0, r1_rdy}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("fix_r0_%0d", i), {31'd0, f_r0_rdy}, 32'd0);
            chk($sformatf("fix_r1_%0d", i), {31'd0, f_r1_rdy}, 32'd1);
            tick();
        end
        REQ1_VALID = 1'b0;
        chk("rr_last_wreg", {27'd0, wreg}, 32'd4);
        chk("rr_last_wdata", wdata, 32'h44);

        // set and clear of reg 9 in the same cycle: set wins
        REQ0_REG = 5'd9; REQ0_DATA = 32'h99;
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
        tick();
        REQ0_VALID = 1'b0; ISSUE_VALID = 1'b0; ISSUE_RD = 5'd0;
        chk("t4_busy9", busy, 32'h0000_0200);
        chk("t4_we", {31'd0, we}, 32'd1);
        chk("t4_wreg", {27'd0, wreg}, 32'd9);

        // register 0: accepted but never written, never busy
        REQ0_VALID = 1'b1; REQ0_REG = 5'd0; REQ0_DATA = 32'hFFFF_FFFF;
        #1;
        chk("t5_r0_ready", {31'd0, r0_rdy}, 32'd1);
        chk("t5_stall_zero", {31'd0, stall}, 32'd0);
        tick();
        REQ0_VALID = 1'b0;
        chk("t5_we", {31'd0, we}, 32'd0);

        // busy 1,2,3 then flush alongside a write to reg 1
        ISSUE_VALID = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            ISSUE_RD = r[4:0];
            tick();
        end
        ISSUE_VALID = 1'b0; ISSUE_RD = 5'd0;
        chk("t6_busy_set", busy, 32'h0000_020E);
        FLUSH = 1'b1; REQ0_VALID = 1'b1; REQ0_REG = 5'd1; REQ0_DATA = 32'h11;
        tick();
        FLUSH = 1'b0; REQ0_VALID = 1'b0;
        chk("t6_busy_flush", busy, 32'd0);
        chk("t6_we", {31'd0, we}, 32'd1);
        chk("t6_wreg", {27'd0, wreg}, 32'd1);
        chk("t6_wdata", wdata, 32'h11);

        // asynchronous reset mid-transfer
        REQ0_VALID = 1'b1; REQ0_REG = 5'd6; REQ0_DATA = 32'h66;
        tick();
        chk("t7_we_before", {31'd0, we}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("t7_we_reset", {31'd0, we}, 32'd0);
        chk("t7_wdata_reset", wdata, 32'd0);
        REQ0_VALID = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
